// File: rtl/phv_arb_pkg.sv
// Shared constants, types and the grant-selection helper for the PHV output arbiter.
// Latency: n/a (package; rr_next is purely combinational).
// Backpressure: n/a.
//
// Contents:
//   C_NUM_QUEUES / QID_WIDTH : queue count and width of the queue-id tag
//   PHV_QUEUE_BIT_OFF        : bit offset of the queue bitmap inside a PHV
//   rr_next()                : first requester at or after a pointer, with wrap
package phv_arb_pkg;

   localparam int C_NUM_QUEUES = 4;
   localparam int QID_WIDTH    = 2;

   // The last stage selects the destination queues from the bitmap that starts
   // at this PHV bit. The arbiter does not decode it; it only sees the result
   // on the four per-queue valids.
   localparam int PHV_QUEUE_BIT_OFF = 141;

   typedef logic [QID_WIDTH-1:0]    qid_t;
   typedef logic [C_NUM_QUEUES-1:0] qmask_t;

   typedef struct packed {
      logic   vld;     // at least one requester present
      qid_t   qid;     // granted queue
      qmask_t onehot;  // one-hot form of qid, all-zero when !vld
   } grant_t;

   // Returns the first set bit of req_mask at or after ptr, wrapping 3->0.
   // Scanning from the farthest offset down to offset 0 lets the nearest
   // requester overwrite any farther one.
   function automatic grant_t rr_next(input qid_t ptr, input qmask_t req_mask);
      grant_t g;
      qid_t   idx;
      g = '0;
      for (int k = C_NUM_QUEUES - 1; k >= 0; k--) begin
         idx = ptr + qid_t'(k);
         if (req_mask[idx]) begin
            g.vld    = 1'b1;
            g.qid    = idx;
            g.onehot = qmask_t'(1) << idx;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/phv_sync_fifo.sv
// Single-clock FIFO for one queue's PHVs; head word is visible combinationally on dout.
// Latency: a word written at edge N appears on dout / clears empty in cycle N+1.
// Backpressure: full is derived from the registered count; writes while full are ignored.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears pointers and count)
//   wr_en, din    : push request and data
//   rd_en         : pop the head word (ignored while empty)
//   dout          : head word
//   empty, full   : registered occupancy flags
module phv_sync_fifo #(
   parameter int WIDTH = 32*64+256,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;

   logic [WIDTH-1:0] mem_q [DEPTH];

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   cnt_t count_q,  count_d;

   logic wr_fire;
   logic rd_fire;

   assign empty   = (count_q == '0);
   assign full    = (count_q == cnt_t'(DEPTH));
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   assign dout    = mem_q[rd_ptr_q];

   // Pointers are exactly AW bits so they wrap on their own; the extra count
   // bit distinguishes full from empty.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;  // idle, or push and pop cancel out
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: a cleared count makes every entry unreachable.
   always_ff @(posedge clk) begin
      if (!rst && wr_fire) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/phv_out_arbiter.sv
// Buffers the last stage's four per-queue PHV outputs and merges them onto one tagged stream.
// Latency: 2 cycles from an accepted input write to phv_out_valid; 1 PHV/cycle sustained.
// Backpressure: phv_out held while !phv_out_ready; phv_fifo_ready_i = queue i not full.
//
// Ports:
//   axis_clk, areset                : clock, synchronous active-high reset
//   phv_in_0..3, phv_in_valid_0..3  : per-queue PHV input from the last stage
//   phv_fifo_ready_0..3             : queue i can take a write this cycle
//   phv_out, phv_out_qid,
//   phv_out_valid, phv_out_ready    : arbitrated PHV stream towards the deparser
//
// Build option: define PHV_ARB_STRICT_PRIO_EN for fixed priority (queue 0 highest)
// instead of round-robin. Ports, latency and handshakes are the same in both builds.
module phv_out_arbiter
   import phv_arb_pkg::*;
#(
   parameter int PHV_LEN    = 32*64+256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 axis_clk,
   input  logic                 areset,

   input  logic [PHV_LEN-1:0]   phv_in_0,
   input  logic [PHV_LEN-1:0]   phv_in_1,
   input  logic [PHV_LEN-1:0]   phv_in_2,
   input  logic [PHV_LEN-1:0]   phv_in_3,
   input  logic                 phv_in_valid_0,
   input  logic                 phv_in_valid_1,
   input  logic                 phv_in_valid_2,
   input  logic                 phv_in_valid_3,
   output logic                 phv_fifo_ready_0,
   output logic                 phv_fifo_ready_1,
   output logic                 phv_fifo_ready_2,
   output logic                 phv_fifo_ready_3,

   output logic [PHV_LEN-1:0]   phv_out,
   output logic [QID_WIDTH-1:0] phv_out_qid,
   output logic                 phv_out_valid,
   input  logic                 phv_out_ready
);

   // ---------------------------------------------------------------------
   // Per-queue input side
   // ---------------------------------------------------------------------
   logic [PHV_LEN-1:0] in_dat_w   [C_NUM_QUEUES];
   logic [PHV_LEN-1:0] head_dat_w [C_NUM_QUEUES];

   qmask_t in_vld_w;
   qmask_t rdy_w;
   qmask_t wr_en_w;
   qmask_t full_w;
   qmask_t empty_w;
   qmask_t pop_w;

   assign in_dat_w[0] = phv_in_0;
   assign in_dat_w[1] = phv_in_1;
   assign in_dat_w[2] = phv_in_2;
   assign in_dat_w[3] = phv_in_3;

   assign in_vld_w = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};

   // Ready comes from the registered FIFO count only, and is forced low for
   // the cycle reset is asserted so nothing is taken while state is cleared.
   assign rdy_w = ~full_w & {C_NUM_QUEUES{~areset}};

   assign phv_fifo_ready_0 = rdy_w[0];
   assign phv_fifo_ready_1 = rdy_w[1];
   assign phv_fifo_ready_2 = rdy_w[2];
   assign phv_fifo_ready_3 = rdy_w[3];

   // A valid without ready is dropped. Multicast needs nothing special: every
   // queue whose valid is high stores its own copy.
   assign wr_en_w = in_vld_w & rdy_w;

   for (genvar q = 0; q < C_NUM_QUEUES; q++) begin : g_queue
      phv_sync_fifo #(
         .WIDTH (PHV_LEN),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (axis_clk),
         .rst   (areset),
         .wr_en (wr_en_w[q]),
         .din   (in_dat_w[q]),
         .rd_en (pop_w[q]),
         .dout  (head_dat_w[q]),
         .empty (empty_w[q]),
         .full  (full_w[q])
      );
   end

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic [PHV_LEN-1:0] phv_out_q,       phv_out_d;
   qid_t               phv_out_qid_q,   phv_out_qid_d;
   logic               phv_out_valid_q, phv_out_valid_d;

   logic   load_w;
   grant_t grant_w;

   // The output register may take a new PHV when it is empty or being consumed.
   assign load_w = !phv_out_valid_q || phv_out_ready;

`ifdef PHV_ARB_STRICT_PRIO_EN
   // Scanning from a fixed pointer of 0 gives lowest-index-wins priority.
   assign grant_w = rr_next(qid_t'(0), ~empty_w);
`else
   qid_t rr_ptr_q, rr_ptr_d;

   assign grant_w = rr_next(rr_ptr_q, ~empty_w);

   // The queue just served drops to lowest priority for the next grant.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (load_w && grant_w.vld) begin
         rr_ptr_d = grant_w.qid + qid_t'(1);
      end
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   // Pop in the same cycle the head word is captured into the output register.
   assign pop_w = (load_w && grant_w.vld) ? grant_w.onehot : '0;

   // ---------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------
   always_comb begin
      phv_out_d       = phv_out_q;
      phv_out_qid_d   = phv_out_qid_q;
      phv_out_valid_d = phv_out_valid_q;
      if (load_w) begin
         // With nothing to send the register goes invalid; data and qid keep
         // their last value since nobody looks at them while invalid.
         phv_out_valid_d = grant_w.vld;
         if (grant_w.vld) begin
            phv_out_d     = head_dat_w[grant_w.qid];
            phv_out_qid_d = grant_w.qid;
         end
      end
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         phv_out_q       <= '0;
         phv_out_qid_q   <= '0;
         phv_out_valid_q <= 1'b0;
      end else begin
         phv_out_q       <= phv_out_d;
         phv_out_qid_q   <= phv_out_qid_d;
         phv_out_valid_q <= phv_out_valid_d;
      end
   end

   assign phv_out       = phv_out_q;
   assign phv_out_qid   = phv_out_qid_q;
   assign phv_out_valid = phv_out_valid_q;

endmodule

// File: tb/tb_phv_out_arbiter.sv
// Directed bench for phv_out_arbiter with a scoreboard queue and an output monitor.
module tb_phv_out_arbiter;
   import phv_arb_pkg::*;

   localparam int PHV_LEN    = 32*64+256;
   localparam int FIFO_DEPTH = 16;

   logic                 axis_clk = 1'b0;
   logic                 areset;
   logic [PHV_LEN-1:0]   in_dat [4];
   logic [3:0]           in_vld;
   wire  [3:0]           fifo_rdy;
   wire  [PHV_LEN-1:0]   phv_out;
   wire  [QID_WIDTH-1:0] phv_out_qid;
   wire                  phv_out_valid;
   logic                 phv_out_ready;

   always #5 axis_clk = ~axis_clk;

   phv_out_arbiter #(
      .PHV_LEN    (PHV_LEN),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .axis_clk         (axis_clk),
      .areset           (areset),
      .phv_in_0         (in_dat[0]),
      .phv_in_1         (in_dat[1]),
      .phv_in_2         (in_dat[2]),
      .phv_in_3         (in_dat[3]),
      .phv_in_valid_0   (in_vld[0]),
      .phv_in_valid_1   (in_vld[1]),
      .phv_in_valid_2   (in_vld[2]),
      .phv_in_valid_3   (in_vld[3]),
      .phv_fifo_ready_0 (fifo_rdy[0]),
      .phv_fifo_ready_1 (fifo_rdy[1]),
      .phv_fifo_ready_2 (fifo_rdy[2]),
      .phv_fifo_ready_3 (fifo_rdy[3]),
      .phv_out          (phv_out),
      .phv_out_qid      (phv_out_qid),
      .phv_out_valid    (phv_out_valid),
      .phv_out_ready    (phv_out_ready)
   );

   typedef struct packed {
      logic [PHV_LEN-1:0] dat;
      logic [1:0]         qid;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   first_v, last_v, n_v;

   function automatic logic [PHV_LEN-1:0] mk(input logic [31:0] tag);
      return {(PHV_LEN/32){tag}};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] tag, input int q);
      exp_t e;
      e.dat = mk(tag);
      e.qid = 2'(q);
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int i;
      i = 0;
      while (sb.size() != 0 && i < 300) begin
         @(posedge axis_clk);
         i++;
      end
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL %s: %0d PHVs never emitted, expected 0 outstanding", name, sb.size());
      end
   endtask

   task automatic reset_dut();
      areset = 1'b1;
      sb.delete();
      step();
      areset = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Monitor: pops the scoreboard on every handshake, and checks the output
   // is frozen across every cycle where it was valid but not accepted.
   // ---------------------------------------------------------------------
   logic               hold_v = 1'b0;
   logic [PHV_LEN-1:0] hold_dat;
   logic [1:0]         hold_qid;

   always @(negedge axis_clk) begin
      exp_t e;
      if (areset) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            n_checks++;
            if (!phv_out_valid || phv_out !== hold_dat || phv_out_qid !== hold_qid) begin
               n_errors++;
               $display("FAIL held_output: got vld=%0b qid=%0d dat=0x%08h, required vld=1 qid=%0d dat=0x%08h",
                        phv_out_valid, phv_out_qid, phv_out[31:0], hold_qid, hold_dat[31:0]);
            end
         end
         if (phv_out_valid && phv_out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_phv: got qid=%0d dat=0x%08h, expected no output",
                        phv_out_qid, phv_out[31:0]);
            end else begin
               e = sb.pop_front();
               if (phv_out !== e.dat || phv_out_qid !== e.qid) begin
                  n_errors++;
                  $display("FAIL out_phv: got qid=%0d dat=0x%08h, expected qid=%0d dat=0x%08h",
                           phv_out_qid, phv_out[31:0], e.qid, e.dat[31:0]);
               end
            end
         end
         hold_v   = phv_out_valid && !phv_out_ready;
         hold_dat = phv_out;
         hold_qid = phv_out_qid;
      end
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      areset        = 1'b1;
      in_vld        = 4'b0;
      phv_out_ready = 1'b0;
      for (int q = 0; q < 4; q++) in_dat[q] = '0;

      // Reset: readies low while reset is asserted, high the cycle after.
      @(negedge axis_clk);
      chk("rst_rdy_during", 32'(fifo_rdy), 32'h0);
      step();
      areset = 1'b0;
      @(negedge axis_clk);
      chk("rst_valid",   32'(phv_out_valid), 32'h0);
      chk("rst_qid",     32'(phv_out_qid),   32'h0);
      chk("rst_out_zero", 32'(phv_out != '0), 32'h0);
      chk("rst_rdy_after", 32'(fifo_rdy),    32'hF);

      // Single PHV on queue 2: valid two cycles after it is presented.
      step();
      phv_out_ready = 1'b1;
      in_vld[2] = 1'b1;
      in_dat[2] = mk(32'hA5A5_A5A5);
      push(32'hA5A5_A5A5, 2);
      @(negedge axis_clk);
      chk("lat_cyc0_valid", 32'(phv_out_valid), 32'h0);
      step();
      in_vld = 4'b0;
      @(negedge axis_clk);
      chk("lat_cyc1_valid", 32'(phv_out_valid), 32'h0);
      step();
      @(negedge axis_clk);
      chk("lat_cyc2_valid", 32'(phv_out_valid), 32'h1);
      chk("lat_cyc2_qid",   32'(phv_out_qid),   32'h2);
      step();
      @(negedge axis_clk);
      chk("lat_cyc3_valid", 32'(phv_out_valid), 32'h0);
      wait_drain("lat_drain");

      // Burst: three PHVs on every queue at once, fresh RR pointer.
      reset_dut();
`ifdef PHV_ARB_STRICT_PRIO_EN
      for (int q = 0; q < 4; q++)
         for (int k = 0; k < 3; k++) push(32'h1000_0000 | (q << 8) | k, q);
`else
      for (int k = 0; k < 3; k++)
         for (int q = 0; q < 4; q++) push(32'h1000_0000 | (q << 8) | k, q);
`endif
      n_v = 0; first_v = -1; last_v = -1;
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               in_vld = 4'hF;
               for (int q = 0; q < 4; q++) in_dat[q] = mk(32'h1000_0000 | (q << 8) | k);
               step();
            end
            in_vld = 4'b0;
         end
         begin
            for (int c = 0; c < 30; c++) begin
               @(negedge axis_clk);
               if (phv_out_valid) begin
                  n_v++;
                  if (first_v < 0) first_v = c;
                  last_v = c;
               end
            end
         end
      join
      chk("burst_valid_cycles", 32'(n_v), 32'd12);
      chk("burst_contiguous",   32'(last_v - first_v + 1), 32'd12);
      wait_drain("burst_drain");

      // Multicast: same PHV on queues 0 and 3 in one cycle.
      in_vld    = 4'b1001;
      in_dat[0] = mk(32'hC0DE_0001);
      in_dat[3] = mk(32'hC0DE_0001);
      push(32'hC0DE_0001, 0);
      push(32'hC0DE_0001, 3);
      step();
      in_vld = 4'b0;
      wait_drain("mcast_drain");

      // Backpressure: a PHV parked in the output register, then 17 writes to queue 1.
      phv_out_ready = 1'b0;
      in_vld[0] = 1'b1;
      in_dat[0] = mk(32'hBB00_0000);
      push(32'hBB00_0000, 0);
      step();
      in_vld = 4'b0;
      step();
      step();
      for (int k = 0; k < 17; k++) begin
         in_vld[1] = 1'b1;
         in_dat[1] = mk(32'hBB10_0000 | k);
         if (k < 16) push(32'hBB10_0000 | k, 1);
         @(negedge axis_clk);
         if (k == 15) chk("bp_rdy_before_16th", 32'(fifo_rdy[1]), 32'h1);
         if (k == 16) chk("bp_rdy_after_16th",  32'(fifo_rdy[1]), 32'h0);
         step();
      end
      in_vld = 4'b0;
      @(negedge axis_clk);
      chk("bp_out_parked", phv_out[31:0], 32'hBB00_0000);
      step();
      phv_out_ready = 1'b1;
      @(negedge axis_clk);
      chk("bp_rdy_before_pop", 32'(fifo_rdy[1]), 32'h0);
      step();
      @(negedge axis_clk);
      chk("bp_rdy_after_pop", 32'(fifo_rdy[1]), 32'h1);
      wait_drain("bp_drain");

      // Held output: ready toggling every cycle while queue 2 drains.
      phv_out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         in_vld[2] = 1'b1;
         in_dat[2] = mk(32'hDD20_0000 | k);
         push(32'hDD20_0000 | k, 2);
         step();
      end
      in_vld = 4'b0;
      for (int c = 0; c < 24; c++) begin
         phv_out_ready = c[0];
         step();
      end
      phv_out_ready = 1'b1;
      wait_drain("toggle_drain");

      // Reset with five PHVs buffered and valids high during the reset cycle.
      phv_out_ready = 1'b0;
      in_vld = 4'hF;
      for (int q = 0; q < 4; q++) in_dat[q] = mk(32'hEE00_0000 | q);
      step();
      in_vld = 4'b0001;
      in_dat[0] = mk(32'hEE00_0010);
      step();
      in_vld = 4'b0;
      step();
      step();
      areset = 1'b1;
      sb.delete();
      in_vld = 4'hF;
      for (int q = 0; q < 4; q++) in_dat[q] = mk(32'hEEFF_0000 | q);
      @(negedge axis_clk);
      chk("mid_rst_rdy_during", 32'(fifo_rdy), 32'h0);
      step();
      areset = 1'b0;
      in_vld = 4'b0;
      @(negedge axis_clk);
      chk("mid_rst_valid",    32'(phv_out_valid), 32'h0);
      chk("mid_rst_rdy",      32'(fifo_rdy),      32'hF);
      chk("mid_rst_out_zero", 32'(phv_out != '0), 32'h0);
      chk("mid_rst_qid",      32'(phv_out_qid),   32'h0);
      phv_out_ready = 1'b1;
      for (int c = 0; c < 20; c++) step();
      in_vld[1] = 1'b1;
      in_dat[1] = mk(32'h0F0F_0001);
      push(32'h0F0F_0001, 1);
      step();
      in_vld = 4'b0;
      wait_drain("post_rst_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
